// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI-Lite response encodings and the read-arbiter state set.
package axil_pkg;

   typedef logic [1:0] axil_resp_t;

   localparam axil_resp_t RESP_OKAY   = 2'b00;
   localparam axil_resp_t RESP_SLVERR = 2'b10;

   // ERR and DRAIN are only reachable when the read watchdog is compiled in.
   typedef enum logic [2:0] {
      IDLE,
      ADDR,
      DATA,
      ERR,
      DRAIN
   } rd_state_t;

endpackage

// File: rtl/axil_interconnect_priority_rd_if.sv
// axil_interconnect_priority_rd_if: master-facing AR/R ports (one lane per master)
// plus the single slave-facing AR/R port of the priority read arbiter.
// modport master = the arbiter (it masters the downstream slave);
// modport slave  = the surrounding fabric / environment.
interface axil_interconnect_priority_rd_if
   import axil_pkg::*;
#(
   parameter int NUMBER_MASTER = 20,
   parameter int ADDR_WIDTH    = 32,
   parameter int DATA_WIDTH    = 32
);
   // master-facing side
   logic [NUMBER_MASTER-1:0][ADDR_WIDTH-1:0] m_axil_araddr;
   logic [NUMBER_MASTER-1:0]                 m_axil_arvalid;
   logic [NUMBER_MASTER-1:0]                 m_axil_arready;
   logic [DATA_WIDTH-1:0]                    m_axil_rdata;
   axil_resp_t                               m_axil_rresp;
   logic [NUMBER_MASTER-1:0]                 m_axil_rvalid;
   logic [NUMBER_MASTER-1:0]                 m_axil_rready;

   // slave-facing side
   logic [ADDR_WIDTH-1:0]                    s_axil_araddr;
   logic                                     s_axil_arvalid;
   logic                                     s_axil_arready;
   logic [DATA_WIDTH-1:0]                    s_axil_rdata;
   axil_resp_t                               s_axil_rresp;
   logic                                     s_axil_rvalid;
   logic                                     s_axil_rready;

   modport master (
      input  m_axil_araddr, m_axil_arvalid, m_axil_rready,
             s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      output m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
             s_axil_araddr, s_axil_arvalid, s_axil_rready
   );

   modport slave (
      output m_axil_araddr, m_axil_arvalid, m_axil_rready,
             s_axil_arready, s_axil_rdata, s_axil_rresp, s_axil_rvalid,
      input  m_axil_arready, m_axil_rdata, m_axil_rresp, m_axil_rvalid,
             s_axil_araddr, s_axil_arvalid, s_axil_rready
   );

endinterface

// File: rtl/axil_priority_encoder.sv
// axil_priority_encoder: combinational find-first-set, bit 0 highest priority.
// Returns the winner as one-hot and as a binary index (all zero when no request).
module axil_priority_encoder #(
   parameter  int WIDTH = 2,
   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_onehot,
   output logic [IDX_W-1:0] o_idx
);

   // scan from the top so the lowest set bit is the last (winning) assignment
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         if (i_req[i]) begin
            o_onehot    = '0;
            o_onehot[i] = 1'b1;
            o_idx       = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/axil_interconnect_priority_rd.sv
// axil_interconnect_priority_rd: N-master to 1-slave AXI-Lite read arbiter/router.
// Fixed priority (master 0 highest). The grant is registered in IDLE and held
// until the R handshake; AR/R paths are combinational through the grant.
// Optional read-response watchdog (ERR/DRAIN states): define AXIL_RD_TIMEOUT_EN.
module axil_interconnect_priority_rd
   import axil_pkg::*;
#(
   parameter int NUMBER_MASTER  = 20,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic aclk,
   input  logic aresetn,
   axil_interconnect_priority_rd_if.master bus
);

   localparam int IDX_W = $clog2(NUMBER_MASTER);

   rd_state_t                r_state, w_state_nxt;
   logic [NUMBER_MASTER-1:0] r_grant_oh;
   logic [IDX_W-1:0]         r_grant_idx;
   logic [NUMBER_MASTER-1:0] w_req_oh;
   logic [IDX_W-1:0]         w_req_idx;
   logic                     w_gnt_arvalid;
   logic                     w_gnt_rready;

   logic [NUMBER_MASTER-1:0] w_arready;
   logic [NUMBER_MASTER-1:0] w_rvalid;
   logic [DATA_WIDTH-1:0]    w_rdata;
   axil_resp_t               w_rresp;
   logic [ADDR_WIDTH-1:0]    w_s_araddr;
   logic                     w_s_arvalid;
   logic                     w_s_rready;

   axil_priority_encoder #(.WIDTH(NUMBER_MASTER)) u_prio (
      .i_req    (bus.m_axil_arvalid),
      .o_onehot (w_req_oh),
      .o_idx    (w_req_idx)
   );

   assign w_gnt_arvalid = |(bus.m_axil_arvalid & r_grant_oh);
   assign w_gnt_rready  = |(bus.m_axil_rready  & r_grant_oh);

`ifdef AXIL_RD_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   logic [TMO_W-1:0] r_tmo_cnt;
   logic             w_tmo_hit;

   assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

   // watchdog: restarts on every state change, counts silent DATA cycles and DRAIN cycles
   always_ff @(posedge aclk) begin
      if (!aresetn)
         r_tmo_cnt <= '0;
      else if (r_state != w_state_nxt)
         r_tmo_cnt <= '0;
      else if ((r_state == DATA && !bus.s_axil_rvalid) || r_state == DRAIN)
         r_tmo_cnt <= r_tmo_cnt + 1'b1;
   end
`else
   // Watchdog compiled out; TIMEOUT_CYCLES is kept so both builds share one parameter list.
   if (TIMEOUT_CYCLES < 2) begin : g_tmo_unsupported
   end
`endif

   // state and grant registers; grant latched on IDLE->ADDR, cleared on any return to IDLE
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_state     <= IDLE;
         r_grant_oh  <= '0;
         r_grant_idx <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_state_nxt == ADDR) begin
            r_grant_oh  <= w_req_oh;
            r_grant_idx <= w_req_idx;
         end else if (w_state_nxt == IDLE) begin
            r_grant_oh  <= '0;
            r_grant_idx <= '0;
         end
      end
   end

   // next state and channel routing; everything idles at 0 / OKAY outside its phase
   always_comb begin
      w_state_nxt = r_state;
      w_arready   = '0;
      w_rvalid    = '0;
      w_rdata     = '0;
      w_rresp     = RESP_OKAY;
      w_s_araddr  = '0;
      w_s_arvalid = 1'b0;
      w_s_rready  = 1'b0;
      case (r_state)
         IDLE: begin
            if (|bus.m_axil_arvalid) w_state_nxt = ADDR;
         end
         ADDR: begin
            w_s_araddr  = bus.m_axil_araddr[r_grant_idx];
            w_s_arvalid = w_gnt_arvalid;
            w_arready   = r_grant_oh & {NUMBER_MASTER{bus.s_axil_arready}};
            if (w_gnt_arvalid && bus.s_axil_arready) w_state_nxt = DATA;
         end
         DATA: begin
            w_rvalid   = r_grant_oh & {NUMBER_MASTER{bus.s_axil_rvalid}};
            w_s_rready = w_gnt_rready;
            w_rdata    = bus.s_axil_rdata;
            w_rresp    = bus.s_axil_rresp;
            if (bus.s_axil_rvalid && w_gnt_rready) w_state_nxt = IDLE;
`ifdef AXIL_RD_TIMEOUT_EN
            // a response arriving on the last watchdog cycle still wins
            else if (w_tmo_hit && !bus.s_axil_rvalid) w_state_nxt = ERR;
`endif
         end
`ifdef AXIL_RD_TIMEOUT_EN
         ERR: begin
            w_rvalid = r_grant_oh;
            w_rresp  = RESP_SLVERR;
            if (w_gnt_rready) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            // swallow a late slave response so it cannot reach the next owner
            w_s_rready = 1'b1;
            if (bus.s_axil_rvalid || w_tmo_hit) w_state_nxt = IDLE;
         end
`endif
         default: w_state_nxt = IDLE;
      endcase
   end

   assign bus.m_axil_arready = w_arready;
   assign bus.m_axil_rvalid  = w_rvalid;
   assign bus.m_axil_rdata   = w_rdata;
   assign bus.m_axil_rresp   = w_rresp;
   assign bus.s_axil_araddr  = w_s_araddr;
   assign bus.s_axil_arvalid = w_s_arvalid;
   assign bus.s_axil_rready  = w_s_rready;

endmodule

// File: tb/tb_axil_interconnect_priority_rd.sv
// tb_axil_interconnect_priority_rd: directed vector tables plus randomized traffic
// against a transaction-level reference (owner + address-accepted flag).
// Define AXIL_RD_TIMEOUT_EN to also run the watchdog sequence (TIMEOUT_CYCLES=8).
module tb_axil_interconnect_priority_rd;

   localparam int N   = 20;
   localparam int AW  = 32;
   localparam int DW  = 32;
   localparam int TMO = 8;

   typedef logic [N-1:0] mask_t;

   typedef struct packed {
      logic          sarv;
      logic [AW-1:0] saddr;
      mask_t         arr;
      mask_t         rv;
      logic          srr;
      logic [DW-1:0] rdata;
      logic [1:0]    rresp;
   } out_t;

   typedef struct {
      logic          rstn;
      mask_t         arv;
      logic          sarr;
      logic          srv;
      logic [DW-1:0] sdata;
      logic [1:0]    sresp;
      mask_t         rrdy;
      out_t          exp;
   } vec_t;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axil_interconnect_priority_rd_if #(.NUMBER_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   axil_interconnect_priority_rd #(
      .NUMBER_MASTER(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .bus     (bus)
   );

   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl[$];
   out_t Z;

   function automatic mask_t m(input int i);
      mask_t r;
      r    = '0;
      r[i] = 1'b1;
      return r;
   endfunction

   // fixed per-master address for the directed tables: master 3 -> 0x40
   function automatic logic [AW-1:0] a(input int i);
      return AW'((i + 1) * 16);
   endfunction

   function automatic out_t o(input logic sarv, input logic [AW-1:0] saddr, input mask_t arr,
                              input mask_t rv, input logic srr, input logic [DW-1:0] rdata,
                              input logic [1:0] rresp);
      out_t r;
      r.sarv = sarv; r.saddr = saddr; r.arr = arr; r.rv = rv;
      r.srr = srr; r.rdata = rdata; r.rresp = rresp;
      return r;
   endfunction

   function automatic vec_t v(input logic rstn, input mask_t arv, input logic sarr,
                              input logic srv, input logic [DW-1:0] sdata, input logic [1:0] sresp,
                              input mask_t rrdy, input out_t e);
      vec_t r;
      r.rstn = rstn; r.arv = arv; r.sarr = sarr; r.srv = srv;
      r.sdata = sdata; r.sresp = sresp; r.rrdy = rrdy; r.exp = e;
      return r;
   endfunction

   function automatic out_t dut_out();
      out_t r;
      r.sarv  = bus.s_axil_arvalid;
      r.saddr = bus.s_axil_araddr;
      r.arr   = bus.m_axil_arready;
      r.rv    = bus.m_axil_rvalid;
      r.srr   = bus.s_axil_rready;
      r.rdata = bus.m_axil_rdata;
      r.rresp = bus.m_axil_rresp;
      return r;
   endfunction

   task automatic check(input string name, input out_t exp);
      out_t act;
      act = dut_out();
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got sarv=%0b saddr=%h arr=%h rv=%h srr=%0b rdata=%h rresp=%0d | want sarv=%0b saddr=%h arr=%h rv=%h srr=%0b rdata=%h rresp=%0d",
                  name, act.sarv, act.saddr, act.arr, act.rv, act.srr, act.rdata, act.rresp,
                  exp.sarv, exp.saddr, exp.arr, exp.rv, exp.srr, exp.rdata, exp.rresp);
      end
   endtask

   task automatic zero_inputs();
      bus.m_axil_arvalid = '0;
      bus.m_axil_rready  = '0;
      bus.s_axil_arready = 1'b0;
      bus.s_axil_rvalid  = 1'b0;
      bus.s_axil_rdata   = '0;
      bus.s_axil_rresp   = 2'b00;
      for (int i = 0; i < N; i++) bus.m_axil_araddr[i] = a(i);
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      zero_inputs();
      repeat (3) @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask

   // drive one row just after the edge, check outputs at the falling edge
   task automatic apply_tbl(input string tag);
      foreach (tbl[k]) begin
         @(posedge aclk); #1;
         aresetn            = tbl[k].rstn;
         bus.m_axil_arvalid = tbl[k].arv;
         bus.s_axil_arready = tbl[k].sarr;
         bus.s_axil_rvalid  = tbl[k].srv;
         bus.s_axil_rdata   = tbl[k].sdata;
         bus.s_axil_rresp   = tbl[k].sresp;
         bus.m_axil_rready  = tbl[k].rrdy;
         @(negedge aclk);
         check($sformatf("%s[%0d]", tag, k), tbl[k].exp);
      end
      tbl.delete();
   endtask

   // random-phase agents and reference
   int            owner;
   bit            addr_taken;
   int            mst_st[N];
   bit            sl_pend, sl_rv;
   int            sl_dly;
   logic [AW-1:0] sl_addr;
   out_t          e;

   initial begin
      Z = '0;
      do_reset();

      // ---------------- directed table ----------------
      tbl.push_back(v(0, '0, 0, 0, 0, 0, '0, Z));                      // reset state
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // master 3 alone, 0x40 -> 0xDEADBEEF OKAY
      tbl.push_back(v(1, m(3), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(3), 1, 0, 0, 0, '0, o(1, a(3), m(3), '0, 0, 0, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'hDEADBEEF, 0, m(3), o(0, 0, '0, m(3), 1, 32'hDEADBEEF, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // masters 2 and 5 together
      tbl.push_back(v(1, m(2) | m(5), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(2) | m(5), 1, 0, 0, 0, '0, o(1, a(2), m(2), '0, 0, 0, 0)));
      tbl.push_back(v(1, m(5), 1, 1, 32'h22, 0, m(2), o(0, 0, '0, m(2), 1, 32'h22, 0)));
      tbl.push_back(v(1, m(5), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(5), 1, 0, 0, 0, '0, o(1, a(5), m(5), '0, 0, 0, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'h55, 0, m(5), o(0, 0, '0, m(5), 1, 32'h55, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // arready low 4 cycles, rready low 3 cycles
      tbl.push_back(v(1, m(1), 0, 0, 0, 0, '0, Z));
      for (int k = 0; k < 4; k++)
         tbl.push_back(v(1, m(1), 0, 0, 0, 0, '0, o(1, a(1), '0, '0, 0, 0, 0)));
      tbl.push_back(v(1, m(1), 1, 0, 0, 0, '0, o(1, a(1), m(1), '0, 0, 0, 0)));
      for (int k = 0; k < 3; k++)
         tbl.push_back(v(1, '0, 0, 1, 32'h11, 0, '0, o(0, 0, '0, m(1), 0, 32'h11, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'h11, 0, m(1), o(0, 0, '0, m(1), 1, 32'h11, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // master 0 arrives while master 7 is in DATA; SLVERR passes through
      tbl.push_back(v(1, m(7), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(7), 1, 0, 0, 0, '0, o(1, a(7), m(7), '0, 0, 0, 0)));
      tbl.push_back(v(1, m(0), 1, 0, 0, 0, m(7), o(0, 0, '0, '0, 1, 0, 0)));
      tbl.push_back(v(1, m(0), 1, 1, 32'h77, 0, m(7), o(0, 0, '0, m(7), 1, 32'h77, 0)));
      tbl.push_back(v(1, m(0), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(0), 1, 0, 0, 0, '0, o(1, a(0), m(0), '0, 0, 0, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'hAA, 2, m(0), o(0, 0, '0, m(0), 1, 32'hAA, 2)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // reset during ADDR, then a fresh request
      tbl.push_back(v(1, m(4), 0, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(4), 0, 0, 0, 0, '0, o(1, a(4), '0, '0, 0, 0, 0)));
      tbl.push_back(v(0, m(4), 0, 0, 0, 0, '0, o(1, a(4), '0, '0, 0, 0, 0)));
      tbl.push_back(v(1, m(4), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(4), 1, 0, 0, 0, '0, o(1, a(4), m(4), '0, 0, 0, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'h44, 0, m(4), o(0, 0, '0, m(4), 1, 32'h44, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // highest index alone
      tbl.push_back(v(1, m(N-1), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(N-1), 1, 0, 0, 0, '0, o(1, a(N-1), m(N-1), '0, 0, 0, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'h19, 0, m(N-1), o(0, 0, '0, m(N-1), 1, 32'h19, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      // every master at once
      tbl.push_back(v(1, '1, 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, '1, 1, 0, 0, 0, '0, o(1, a(0), m(0), '0, 0, 0, 0)));
      tbl.push_back(v(1, ~m(0), 1, 1, 32'h1, 0, m(0), o(0, 0, '0, m(0), 1, 32'h1, 0)));
      tbl.push_back(v(1, ~m(0), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, ~m(0), 1, 0, 0, 0, '0, o(1, a(1), m(1), '0, 0, 0, 0)));
      tbl.push_back(v(1, ~(m(0) | m(1)), 1, 1, 32'h2, 0, m(1), o(0, 0, '0, m(1), 1, 32'h2, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      apply_tbl("dir");

      // ---------------- randomized traffic ----------------
      do_reset();
      owner = -1; addr_taken = 0;
      sl_pend = 0; sl_rv = 0; sl_dly = 0; sl_addr = '0;
      for (int i = 0; i < N; i++) mst_st[i] = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge aclk); #1;
         for (int i = 0; i < N; i++) begin
            if (mst_st[i] == 0 && $urandom_range(7) == 0) begin
               mst_st[i] = 1;
               bus.m_axil_araddr[i] = $urandom;
            end
            bus.m_axil_arvalid[i] = (mst_st[i] == 1);
         end
         bus.m_axil_rready  = mask_t'($urandom);
         bus.s_axil_arready = 1'($urandom_range(1));
         if (sl_pend && !sl_rv) begin
            if (sl_dly == 0) begin
               sl_rv              = 1;
               bus.s_axil_rdata   = sl_addr ^ 32'h5A5A_0000;
               bus.s_axil_rresp   = 2'($urandom_range(3));
            end else sl_dly--;
         end
         if (!sl_rv) begin
            bus.s_axil_rdata = $urandom;
            bus.s_axil_rresp = 2'b00;
         end
         bus.s_axil_rvalid = sl_rv;

         @(negedge aclk);
         // expected view from the transaction reference
         e = '0;
         if (owner >= 0 && !addr_taken) begin
            e.sarv       = bus.m_axil_arvalid[owner];
            e.saddr      = bus.m_axil_araddr[owner];
            e.arr[owner] = bus.s_axil_arready;
         end else if (owner >= 0) begin
            e.rv[owner] = bus.s_axil_rvalid;
            e.srr       = bus.m_axil_rready[owner];
            e.rdata     = bus.s_axil_rdata;
            e.rresp     = bus.s_axil_rresp;
         end
         check("rand", e);

         // reference: bus free -> lowest requester now owns it from next cycle
         if (owner < 0) begin
            for (int i = 0; i < N; i++)
               if (bus.m_axil_arvalid[i]) begin owner = i; addr_taken = 0; break; end
         end else if (!addr_taken) begin
            if (bus.m_axil_arvalid[owner] && bus.s_axil_arready) addr_taken = 1;
         end else if (bus.s_axil_rvalid && bus.m_axil_rready[owner]) begin
            owner = -1;
         end

         // agents react to what the DUT showed
         for (int i = 0; i < N; i++) begin
            if (mst_st[i] == 1 && bus.m_axil_arready[i]) mst_st[i] = 2;
            else if (mst_st[i] == 2 && bus.m_axil_rvalid[i] && bus.m_axil_rready[i]) mst_st[i] = 0;
         end
         if (sl_rv && bus.s_axil_rready) begin sl_rv = 0; sl_pend = 0; end
         if (bus.s_axil_arvalid && bus.s_axil_arready) begin
            sl_pend = 1;
            sl_dly  = int'($urandom_range(4));
            sl_addr = bus.s_axil_araddr;
         end
      end

`ifdef AXIL_RD_TIMEOUT_EN
      // ---------------- watchdog sequence ----------------
      do_reset();
      tbl.push_back(v(1, m(6), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(6), 1, 0, 0, 0, '0, o(1, a(6), m(6), '0, 0, 0, 0)));
      for (int k = 0; k < TMO; k++)
         tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, '0, 0, 0, 32'h1234, 0, '0, o(0, 0, '0, m(6), 0, 0, 2)));
      tbl.push_back(v(1, '0, 0, 0, 32'h1234, 0, m(6), o(0, 0, '0, m(6), 0, 0, 2)));
      tbl.push_back(v(1, m(9), 1, 0, 0, 0, '0, o(0, 0, '0, '0, 1, 0, 0)));
      tbl.push_back(v(1, m(9), 1, 1, 32'h5, 0, '0, o(0, 0, '0, '0, 1, 0, 0)));
      tbl.push_back(v(1, m(9), 1, 0, 0, 0, '0, Z));
      tbl.push_back(v(1, m(9), 1, 0, 0, 0, '0, o(1, a(9), m(9), '0, 0, 0, 0)));
      for (int k = 0; k < TMO - 1; k++)
         tbl.push_back(v(1, '0, 0, 0, 0, 0, m(9), o(0, 0, '0, '0, 1, 0, 0)));
      tbl.push_back(v(1, '0, 0, 1, 32'h99, 0, m(9), o(0, 0, '0, m(9), 1, 32'h99, 0)));
      tbl.push_back(v(1, '0, 0, 0, 0, 0, '0, Z));
      apply_tbl("tmo");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/axil_interconnect_priority_rd.md
# axil_interconnect_priority_rd

N-master to 1-slave AXI-Lite read-path arbiter and router for the priority interconnect. Grants the AR/R channels to the lowest-indexed master presenting `arvalid`, forwards its address to the single downstream slave, routes the read response back, and holds the grant until the R handshake completes. Read-side counterpart of the interconnect's write arbiter; sits between the master-facing ports and the slave port.

## Interface
- `NUMBER_MASTER`, 20: number of upstream masters, ≥2.
- `ADDR_WIDTH`, 32: AR address width.
- `DATA_WIDTH`, 32: R data width.
- `TIMEOUT_CYCLES`, 256: read-response watchdog limit, ≥2; used only with `AXIL_RD_TIMEOUT_EN`.

- `aclk` in 1: clock.
- `aresetn` in 1: synchronous, active-low reset.
- `m_axil_araddr` in NUMBER_MASTER×ADDR_WIDTH: per-master read address (`m_` = master-facing).
- `m_axil_arvalid` in NUMBER_MASTER: per-master AR valid.
- `m_axil_arready` out NUMBER_MASTER: per-master AR ready.
- `m_axil_rdata` out DATA_WIDTH: read data, broadcast to all masters.
- `m_axil_rresp` out 2: read response, broadcast.
- `m_axil_rvalid` out NUMBER_MASTER: per-master R valid; only the granted bit can be 1.
- `m_axil_rready` in NUMBER_MASTER: per-master R ready.
- `s_axil_araddr` out ADDR_WIDTH, `s_axil_arvalid` out 1, `s_axil_arready` in 1: slave-facing AR channel.
- `s_axil_rdata` in DATA_WIDTH, `s_axil_rresp` in 2, `s_axil_rvalid` in 1, `s_axil_rready` out 1: slave-facing R channel.

## Operation
- Fixed priority: master index 0 is highest. The grant is registered as a one-hot vector plus its binary index.
- IDLE:
  - If any `m_axil_arvalid` is set, latch the winner and go to ADDR.
  - Otherwise stay in IDLE.
  - All handshake outputs are 0.
- ADDR:
  - `s_axil_araddr` = `m_axil_araddr[g]`.
  - `s_axil_arvalid` = `m_axil_arvalid[g]`.
  - `m_axil_arready[g]` = `s_axil_arready`.
  - On `arvalid && arready`, go to DATA.
- DATA:
  - `m_axil_rvalid[g]` = `s_axil_rvalid`.
  - `s_axil_rready` = `m_axil_rready[g]`.
  - `m_axil_rdata`/`m_axil_rresp` = slave values.
  - On `s_axil_rvalid && m_axil_rready[g]`, clear the grant and go to IDLE.
- Non-granted masters see `arready`=0 and `rvalid`=0 at all times.
- New requests arriving while the grant is held do not pre-empt it; they are arbitrated in the next IDLE.
- Reset mid-transaction:
  - Returns to IDLE with the grant cleared and all outputs 0.
  - An in-flight slave response is not tracked across reset.

## Timing
- Reset values:
  - `m_axil_arready`, `m_axil_rvalid`, `s_axil_arvalid`, `s_axil_rready` = 0.
  - `s_axil_araddr`, `m_axil_rdata` = 0.
  - `m_axil_rresp` = OKAY.
- Request visible in cycle 0 → grant registered at edge 1 → `s_axil_arvalid` high in cycle 1.
- AR and R paths are combinational through the registered grant. There is no added latency beyond the grant cycle.
- Minimum of 3 cycles per transaction (IDLE, ADDR, DATA). One IDLE cycle always separates consecutive grants.
- Two requests in the same cycle: the lower index wins. The higher index waits with `arvalid` held, as required by AXI.

## Configuration
- `AXIL_RD_TIMEOUT_EN` defined:
  - A counter of width `$clog2(TIMEOUT_CYCLES)` clears on DATA entry and increments each DATA cycle with `s_axil_rvalid`=0.
  - In the cycle where the count equals `TIMEOUT_CYCLES-1` and `rvalid`=0, the next state is ERR. If `rvalid` arrives in that same cycle, the normal response wins.
  - ERR: drives `m_axil_rvalid[g]`=1, `rdata`=0, `rresp`=SLVERR (2'b10), `s_axil_rready`=0. On `m_axil_rready[g]`, go to DRAIN.
  - DRAIN: all master outputs 0 and `s_axil_rready`=1. Leave to IDLE on `s_axil_rvalid`, or after another `TIMEOUT_CYCLES` cycles. Either way the grant is cleared.
- `AXIL_RD_TIMEOUT_EN` undefined:
  - No counter and no ERR or DRAIN states.
  - DATA waits indefinitely for the slave.

## Structure
- `axil_pkg`:
  - `axil_resp_t` and the constants `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10.
  - The read-arbiter state enum (IDLE, ADDR, DATA, ERR, DRAIN). ERR and DRAIN are unused without the macro.
- Sub-module `axil_priority_encoder`, parameter `WIDTH`: combinational find-first-set. Outputs a one-hot vector and a binary index. It is shared with the write arbiter.

## Test plan
- Master 3 alone issues address 0x40; slave returns rdata 0xDEADBEEF OKAY → master 3 receives it; `s_axil_arvalid` rises 1 cycle after `arvalid`; other masters' `rvalid` stays 0.
- Masters 2 and 5 request in the same cycle → master 2 is served first; master 5's address appears on the slave port after master 2's R handshake plus one IDLE cycle.
- Slave holds `arready` low for 4 cycles and master holds `rready` low for 3 cycles → no handshake is lost; the grant is held until the R handshake.
- Master 0 requests while master 7's transaction is in DATA → master 7 completes unpre-empted; master 0 is granted next.
- Reset asserted during ADDR → next cycle all outputs are 0 and state is IDLE; a fresh request is served normally.
- With `AXIL_RD_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, slave never sends `rvalid` → after 8 DATA cycles the master gets SLVERR with rdata 0; a late slave `rvalid` is drained with `s_axil_rready`=1; the next master is then served.
